alu_arbiter: RTL

Two-requester front end for the shared combinational 4-bit ALU (12-bit command word in, 4-bit `sum` out). It accepts commands over a valid/ready handshake and arbitrates round-robin when both requesters are active. It holds the granted command on the ALU input for a programmable settle time, registers the ALU result and returns it to the requester that issued the command. It sits between the issuing units and the ALU, and is the only driver of the ALU input.

---
 rtl/alu_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for the shared 4-bit ALU
//
// Purpose:
//   Accepts 12-bit commands from two requesters over valid/ready handshakes.
//   When both requesters are valid at once, grants alternate between them.
//   The granted command is driven on alu_in and held for SETTLE_CYCLES cycles.
//   alu_sum is then registered and returned to the requester that issued the
//   command, together with a one-cycle rspN_valid pulse.
//
// Parameters:
//   SETTLE_CYCLES  cycles alu_in is held before alu_sum is sampled (1..15)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req0_valid/cmd/ready     requester 0 command handshake (ready is combinational)
//   req1_valid/cmd/ready     requester 1 command handshake
//   rsp0_valid/data          requester 0 result (pulse / held data)
//   rsp1_valid/data          requester 1 result
//   alu_in                   registered ALU command drive
//   alu_sum                  ALU result input
//   busy                     high while an operation is settling
//   op_count0/1              completed-operation counters, 8-bit wrapping
//                            (present only when ALU_ARBITER_STATS_EN is defined)
//
// Optional feature macro: ALU_ARBITER_STATS_EN

module alu_arbiter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [11:0] req0_cmd,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [11:0] req1_cmd,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [3:0]  rsp0_data,
    output logic        rsp1_valid,
    output logic [3:0]  rsp1_data,
    output logic [11:0] alu_in,
    input  logic [3:0]  alu_sum,
`ifdef ALU_ARBITER_STATS_EN
    output logic [7:0]  op_count0,
    output logic [7:0]  op_count1,
`endif
    output logic        busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [11:0] alu_in_q, alu_in_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [3:0]  rsp0_data_q, rsp0_data_d;
    logic [3:0]  rsp1_data_q, rsp1_data_d;
`ifdef ALU_ARBITER_STATS_EN
    logic [7:0]  op_count0_q, op_count0_d;
    logic [7:0]  op_count1_q, op_count1_d;
`endif

    logic grant;
    logic idle;

    // On a tie the requester that did not win last time goes next; otherwise
    // the single valid requester wins (grant = req1_valid covers both cases).
    assign grant = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign idle  = (state_q == IDLE);

    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        alu_in_d     = alu_in_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
`ifdef ALU_ARBITER_STATS_EN
        op_count0_d  = op_count0_q;
        op_count1_d  = op_count1_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    alu_in_d     = req1_ready ? req1_cmd : req0_cmd;
                    owner_d      = req1_ready;
                    last_grant_d = req1_ready;
                    cnt_d        = CNT_INIT;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        rsp1_data_d  = alu_sum;
                        rsp1_valid_d = 1'b1;
`ifdef ALU_ARBITER_STATS_EN
                        op_count1_d  = op_count1_q + 8'd1;
`endif
                    end else begin
                        rsp0_data_d  = alu_sum;
                        rsp0_valid_d = 1'b1;
`ifdef ALU_ARBITER_STATS_EN
                        op_count0_d  = op_count0_q + 8'd1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_in_q     <= 12'h000;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 4'h0;
            rsp1_data_q  <= 4'h0;
`ifdef ALU_ARBITER_STATS_EN
            op_count0_q  <= 8'h00;
            op_count1_q  <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            alu_in_q     <= alu_in_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
`ifdef ALU_ARBITER_STATS_EN
            op_count0_q  <= op_count0_d;
            op_count1_q  <= op_count1_d;
`endif
        end
    end

    assign alu_in     = alu_in_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign busy       = (state_q == SETTLE);
`ifdef ALU_ARBITER_STATS_EN
    assign op_count0  = op_count0_q;
    assign op_count1  = op_count1_q;
`endif

endmodule
